ram_ctrl: RTL and testbench

RAM_CTRL -- requirements
Module: ram_ctrl

---
 rtl/ram_ctrl.sv | 66 ++++++
 tb/tb_ram_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_ctrl.sv
// ram_ctrl: clears a single-port RAM after reset, then serves one read or write at a time over a shared tri-state bus
module ram_ctrl #(
  parameter int ADDRESS_BITS = 1,
  parameter int DATA_BITS = 1,
  parameter logic [DATA_BITS-1:0] INIT_VALUE = {DATA_BITS{1'b0}}
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDRESS_BITS-1:0] req_address,
  input  logic [DATA_BITS-1:0]    req_data,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_BITS-1:0]    rsp_data,
  output logic                    init_done,
  output logic                    mem_write,
  output logic [ADDRESS_BITS-1:0] mem_address,
  inout  wire  [DATA_BITS-1:0]    mem_data
);
  typedef enum logic [3:0] {
    INIT_SETUP, INIT_STROBE, IDLE, W_SETUP, W_STROBE, W_HOLD, R_ADDR, R_SAMPLE, RESP
  } state_t;
  state_t state, state_n;
  logic [DATA_BITS-1:0] data_q;
  logic last;
  assign last = mem_address == {ADDRESS_BITS{1'b1}};
  assign req_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  assign mem_write = state == INIT_STROBE || state == W_STROBE;
  assign mem_data = mem_write ? (state == INIT_STROBE ? INIT_VALUE : data_q) : {DATA_BITS{1'bz}};
  always_comb begin
    state_n = state;
    case (state)
      INIT_SETUP:  state_n = INIT_STROBE;
      INIT_STROBE: state_n = last ? IDLE : INIT_SETUP;
      IDLE:        state_n = req_valid ? (req_write ? W_SETUP : R_ADDR) : IDLE;
      W_SETUP:     state_n = W_STROBE;
      W_STROBE:    state_n = W_HOLD;
      W_HOLD:      state_n = IDLE;
      R_ADDR:      state_n = R_SAMPLE;
      R_SAMPLE:    state_n = RESP;
      RESP:        state_n = rsp_ready ? IDLE : RESP;
      default:     state_n = INIT_SETUP;
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= INIT_SETUP;
      mem_address <= '0;
      data_q      <= '0;
      rsp_data    <= '0;
      init_done   <= 1'b0;
    end else begin
      state <= state_n;
      if (state == INIT_STROBE && !last) mem_address <= mem_address + ADDRESS_BITS'(1);
      if (state == INIT_STROBE && last) init_done <= 1'b1;
      if (req_valid && req_ready) begin
        mem_address <= req_address;
        data_q      <= req_data;
      end
      if (state == R_SAMPLE) rsp_data <= mem_data;
    end
  end
endmodule

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl: randomized self-checking bench for ram_ctrl against an array model of the RAM
module tb_ram_ctrl;
  localparam int AB = 2;
  localparam int DB = 4;
  logic clock = 0, reset = 0, req_valid = 0, req_write = 0, rsp_ready = 0, ram_oe = 1;
  logic [AB-1:0] req_address = '0;
  logic [DB-1:0] req_data = '0;
  wire req_ready, rsp_valid, init_done, mem_write;
  wire [AB-1:0] mem_address;
  wire [DB-1:0] rsp_data, mem_data;
  logic [DB-1:0] ram [4];
  logic [DB-1:0] ref_mem [4];
  logic [AB-1:0] log_a [$];
  logic [DB-1:0] log_d [$];
  int checks = 0, passes = 0, tmo = 0, viol = 0, leak = 0, rsp_cycles = 0;
  logic prev_mw = 0;
  logic [AB-1:0] prev_a = '0;

  ram_ctrl #(.ADDRESS_BITS(AB), .DATA_BITS(DB), .INIT_VALUE(4'h0)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_address(req_address), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .init_done(init_done), .mem_write(mem_write), .mem_address(mem_address), .mem_data(mem_data)
  );

  always #5 clock = ~clock;

  // Asynchronous-read RAM: drives the bus whenever the controller is not writing
  assign mem_data = (!mem_write && ram_oe) ? ram[mem_address] : 4'bz;
  always @(posedge clock) if (mem_write === 1'b1) ram[mem_address] <= mem_data;

  always begin
    @(negedge clock);
    #2;
    if (mem_write === 1'b1) begin
      log_a.push_back(mem_address);
      log_d.push_back(mem_data);
      if (prev_mw === 1'b1 || mem_address !== prev_a) viol++;
    end
    if (mem_write === 1'b0 && !ram_oe && mem_data !== 4'bz && mem_data !== 4'h0) leak++;
    if (rsp_valid === 1'b1) rsp_cycles++;
    prev_mw = mem_write;
    prev_a = mem_address;
  end

  task automatic wait_idle;
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 40) begin @(negedge clock); n++; end
    if (req_ready !== 1'b1) tmo++;
  endtask

  task automatic wait_rsp;
    int n;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin @(negedge clock); n++; end
    if (rsp_valid !== 1'b1) tmo++;
  endtask

  task automatic issue(input logic w, input logic [AB-1:0] a, input logic [DB-1:0] d);
    wait_idle();
    req_valid = 1; req_write = w; req_address = a; req_data = d;
    @(negedge clock);
    req_valid = 0; req_write = 1'($urandom); req_address = AB'($urandom); req_data = DB'($urandom);
    if (w) ref_mem[a] = d;
  endtask

  task automatic do_init(output int n);
    n = 0;
    reset = 1;
    for (int i = 0; i < 4; i++) ref_mem[i] = '0;
    while (init_done !== 1'b1 && n < 40) begin @(negedge clock); n++; end
  endtask

  task automatic test_reset;
    int bad;
    logic [2:0] first;
    logic ok;
    reset = 0; req_valid = 0; rsp_ready = 0; ram_oe = 1;
    repeat (2) @(negedge clock);
    checks++;
    if ({mem_write, mem_address, req_ready, rsp_valid, rsp_data, init_done} !== 10'b0)
      $display("FAIL reset_state got %b want 0", {mem_write, mem_address, req_ready, rsp_valid, rsp_data, init_done});
    else passes++;
    log_a.delete(); log_d.delete();
    reset = 1; bad = 0; first = '0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      if (i == 1) first = {mem_write, mem_address};
      if (i < 8 && (init_done !== 1'b0 || req_ready !== 1'b0)) bad++;
    end
    checks++;
    if (first !== 3'b100) $display("FAIL first_edge got write/addr %b want 100", first); else passes++;
    checks++;
    if (bad != 0) $display("FAIL init_early got %0d early cycles want 0", bad); else passes++;
    checks++;
    if ({init_done, req_ready} !== 2'b11) $display("FAIL init_done_8 got %b want 11", {init_done, req_ready}); else passes++;
    ok = log_a.size() == 4;
    for (int i = 0; i < log_a.size() && i < 4; i++) if (log_a[i] !== AB'(i) || log_d[i] !== 4'h0) ok = 0;
    checks++;
    if (!ok) $display("FAIL init_sweep got %0d pulses want 4 at addr 0..3 data 0", log_a.size()); else passes++;
    for (int i = 0; i < 4; i++) ref_mem[i] = '0;
  endtask

  task automatic test_write_read;
    logic r1, r2;
    int c0;
    log_a.delete(); log_d.delete();
    issue(1, 2'd2, 4'hA);
    repeat (2) @(negedge clock);
    checks++;
    if (req_ready !== 1'b0) $display("FAIL wr_ready_early got %b want 0", req_ready); else passes++;
    @(negedge clock);
    checks++;
    if (req_ready !== 1'b1) $display("FAIL wr_ready_3 got %b want 1", req_ready); else passes++;
    checks++;
    if (log_a.size() != 1 || log_a[0] !== 2'd2 || log_d[0] !== 4'hA)
      $display("FAIL wr_pulse got %0d pulses want 1 at addr 2 data a", log_a.size());
    else passes++;
    rsp_ready = 1; c0 = rsp_cycles;
    issue(0, 2'd2, 4'h0);
    r1 = rsp_valid;
    @(negedge clock);
    r2 = rsp_valid;
    @(negedge clock);
    checks++;
    if ({r1, r2, rsp_valid} !== 3'b001 || rsp_data !== ref_mem[2])
      $display("FAIL rd_latency got valid %b data %h want 001 data %h", {r1, r2, rsp_valid}, rsp_data, ref_mem[2]);
    else passes++;
    @(negedge clock);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_cycles - c0 != 1)
      $display("FAIL rd_return got valid %b ready %b cycles %0d want 0 1 1", rsp_valid, req_ready, rsp_cycles - c0);
    else passes++;
    rsp_ready = 0;
  endtask

  task automatic test_backpressure;
    int bad;
    issue(1, 2'd1, 4'h5);
    rsp_ready = 0;
    issue(0, 2'd1, 4'h0);
    repeat (2) @(negedge clock);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clock);
      if (rsp_valid !== 1'b1 || rsp_data !== ref_mem[1] || req_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL bp_hold got %0d unstable cycles data %h want 0 data %h", bad, rsp_data, ref_mem[1]); else passes++;
    rsp_ready = 1;
    @(negedge clock);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL bp_release got valid %b ready %b want 0 1", rsp_valid, req_ready); else passes++;
    rsp_ready = 0;
  endtask

  task automatic test_overwrite;
    wait_idle();
    ram_oe = 0; leak = 0;
    log_a.delete(); log_d.delete();
    issue(1, 2'd0, 4'h1);
    issue(1, 2'd0, 4'hF);
    wait_idle();
    ram_oe = 1;
    checks++;
    if (log_a.size() != 2 || log_a[0] !== 2'd0 || log_d[0] !== 4'h1 || log_a[1] !== 2'd0 || log_d[1] !== 4'hF)
      $display("FAIL ow_pulses got %0d pulses want 2 (0:1, 0:f)", log_a.size());
    else passes++;
    checks++;
    if (leak != 0) $display("FAIL ow_bus_z got %0d driven idle cycles want 0", leak); else passes++;
    rsp_ready = 1;
    issue(0, 2'd0, 4'h0);
    wait_rsp();
    checks++;
    if (rsp_data !== ref_mem[0]) $display("FAIL ow_read got %h want %h", rsp_data, ref_mem[0]); else passes++;
    @(negedge clock);
    rsp_ready = 0;
  endtask

  task automatic test_stray;
    int bad, c0;
    reset = 0;
    @(negedge clock);
    req_valid = 1; req_write = 0; req_address = 2'd0; rsp_ready = 1;
    c0 = rsp_cycles; bad = 0;
    reset = 1;
    for (int i = 0; i < 4; i++) ref_mem[i] = '0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      if (i < 8 && req_ready !== 1'b0) bad++;
    end
    req_valid = 0;
    checks++;
    if (bad != 0 || init_done !== 1'b1) $display("FAIL stray_init got %0d early accepts done %b want 0 1", bad, init_done); else passes++;
    repeat (5) @(negedge clock);
    checks++;
    if (rsp_cycles != c0 || req_ready !== 1'b1)
      $display("FAIL stray_rsp got %0d rsp cycles ready %b want 0 1", rsp_cycles - c0, req_ready);
    else passes++;
    rsp_ready = 0;
  endtask

  task automatic test_reset_mid;
    int n;
    rsp_ready = 0;
    issue(1, 2'd0, 4'h9);
    issue(0, 2'd0, 4'h0);
    wait_rsp();
    reset = 0;
    #1;
    checks++;
    if ({rsp_valid, rsp_data, req_ready, init_done, mem_address} !== 9'b0)
      $display("FAIL mid_read_reset got %b want 0", {rsp_valid, rsp_data, req_ready, init_done, mem_address});
    else passes++;
    @(negedge clock);
    do_init(n);
    checks++;
    if (n != 8) $display("FAIL mid_read_init got %0d cycles want 8", n); else passes++;
    issue(1, 2'd3, 4'h7);
    @(negedge clock);
    checks++;
    if (mem_write !== 1'b1 || mem_address !== 2'd3) $display("FAIL mid_strobe got %b/%0d want 1/3", mem_write, mem_address); else passes++;
    reset = 0;
    #1;
    checks++;
    if (mem_write !== 1'b0 || mem_address !== 2'd0) $display("FAIL mid_write_drop got %b/%0d want 0/0", mem_write, mem_address); else passes++;
    @(negedge clock);
    do_init(n);
    checks++;
    if (n != 8) $display("FAIL mid_write_init got %0d cycles want 8", n); else passes++;
    rsp_ready = 1;
    issue(0, 2'd3, 4'h0);
    wait_rsp();
    checks++;
    if (rsp_data !== ref_mem[3]) $display("FAIL mid_read_back got %h want %h", rsp_data, ref_mem[3]); else passes++;
    @(negedge clock);
    rsp_ready = 0;
  endtask

  task automatic test_random;
    logic w, v2, r3;
    logic [AB-1:0] a;
    logic [DB-1:0] d, exp_d;
    int hold, bad;
    for (int t = 0; t < 40; t++) begin
      w = 1'($urandom_range(0, 1));
      a = AB'($urandom);
      d = DB'($urandom);
      if (w) begin
        issue(1, a, d);
        repeat (2) @(negedge clock);
        r3 = req_ready;
        @(negedge clock);
        checks++;
        if (r3 !== 1'b0 || req_ready !== 1'b1) $display("FAIL rnd_write %0d got ready %b%b want 01", t, r3, req_ready); else passes++;
      end else begin
        hold = $urandom_range(0, 3);
        exp_d = ref_mem[a];
        rsp_ready = hold == 0;
        issue(0, a, d);
        @(negedge clock);
        v2 = rsp_valid;
        @(negedge clock);
        bad = 0;
        for (int k = 0; k < hold; k++) begin
          @(negedge clock);
          if (rsp_valid !== 1'b1 || rsp_data !== exp_d) bad++;
        end
        checks++;
        if (v2 !== 1'b0 || rsp_valid !== 1'b1 || rsp_data !== exp_d || bad != 0)
          $display("FAIL rnd_read %0d addr %0d got valid %b%b data %h unstable %0d want 01 data %h", t, a, v2, rsp_valid, rsp_data, bad, exp_d);
        else passes++;
        rsp_ready = 1;
        @(negedge clock);
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL rnd_release %0d got %b%b want 01", t, rsp_valid, req_ready); else passes++;
        rsp_ready = 0;
      end
    end
  endtask

  task automatic test_protocol;
    checks++;
    if (viol != 0) $display("FAIL mem_protocol got %0d violations want 0", viol); else passes++;
    checks++;
    if (tmo != 0) $display("FAIL timeouts got %0d want 0", tmo); else passes++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_backpressure();
    test_overwrite();
    test_stray();
    test_reset_mid();
    test_random();
    test_protocol();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1);
  end
endmodule
